i2c_ioexp_multi: RTL

I2C_IOEXP_MULTI -- requirements
Module: i2c_ioexp_multi

---
 rtl/i2c_ioexp_pkg.sv | 26 ++
 rtl/i2c_basic.sv | 126 ++++++++++++
 rtl/i2c_ioexp_multi.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/i2c_ioexp_pkg.sv
// Shared definitions for the PCAL6416A multi-expander I2C writer.
// Holds the controller/engine state types and the expander register addresses.
package i2c_ioexp_pkg;
    localparam int MAX_DEV = 4;
    localparam int IDX_W   = $clog2(MAX_DEV);

    localparam logic [7:0] PCAL_REG_OUTPUT0 = 8'h02;
    localparam logic [7:0] PCAL_REG_CONFIG0 = 8'h06;

    typedef enum logic [2:0] {
        INIT_ISSUE,
        INIT_WAIT,
        IDLE,
        UPD_ISSUE,
        UPD_WAIT
    } ioexp_state_e;

    typedef enum logic [2:0] {
        E_IDLE,
        E_START,
        E_LO,
        E_HI,
        E_STOP0,
        E_STOP1
    } i2c_state_e;
endpackage

// File: rtl/i2c_basic.sv
// Write-only I2C master: START, address+W, num_wr_bytes data bytes, STOP.
// sdata is open-drain style: a 1 is sent by releasing the line (sdata_oe_n=1).
module i2c_basic
    import i2c_ioexp_pkg::*;
#(
    parameter int CLK_DIV_BITS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] addr,
    input  logic [1:0] num_wr_bytes,
    input  logic [7:0] wr_data0,
    input  logic [7:0] wr_data1,
    input  logic [7:0] wr_data2,
    input  logic       start,
    output logic       done,
    output logic       sclk,
    output logic       sdata,
    output logic       sdata_oe_n
);
    i2c_state_e              st_q, st_d;
    logic [CLK_DIV_BITS-1:0] div_q, div_d;
    logic [3:0]              bit_q, bit_d;
    logic [1:0]              byte_q, byte_d, last_q, last_d;
    logic [7:0]              sh_q, sh_d, nxt_byte;
    logic [23:0]             dat_q, dat_d;
    logic                    scl_q, scl_d, sda_q, sda_d;
    logic                    tick;

    // One tick per half sclk period.
    assign tick = (div_q == '1);

    always_comb begin
        st_d   = st_q;
        div_d  = (st_q == E_IDLE) ? '0 : div_q + CLK_DIV_BITS'(1);
        bit_d  = bit_q;
        byte_d = byte_q;
        last_d = last_q;
        sh_d   = sh_q;
        dat_d  = dat_q;
        scl_d  = scl_q;
        sda_d  = sda_q;
        done   = 1'b0;
        case (byte_q)
            2'd0:    nxt_byte = dat_q[23:16];
            2'd1:    nxt_byte = dat_q[15:8];
            default: nxt_byte = dat_q[7:0];
        endcase
        case (st_q)
            E_IDLE: if (start) begin
                sda_d  = 1'b0;
                sh_d   = {addr, 1'b0};
                dat_d  = {wr_data0, wr_data1, wr_data2};
                last_d = num_wr_bytes;
                bit_d  = '0;
                byte_d = '0;
                st_d   = E_START;
            end
            E_START: if (tick) begin
                scl_d = 1'b0;
                sda_d = sh_q[7];
                st_d  = E_LO;
            end
            E_LO: if (tick) begin
                scl_d = 1'b1;
                st_d  = E_HI;
            end
            E_HI: if (tick) begin
                scl_d = 1'b0;
                st_d  = E_LO;
                if (bit_q == 4'd8) begin
                    if (byte_q == last_q) begin
                        sda_d = 1'b0;
                        st_d  = E_STOP0;
                    end else begin
                        byte_d = byte_q + 2'd1;
                        bit_d  = '0;
                        sh_d   = nxt_byte;
                        sda_d  = nxt_byte[7];
                    end
                end else if (bit_q == 4'd7) begin
                    // Release the line for the slave's acknowledge slot.
                    bit_d = 4'd8;
                    sda_d = 1'b1;
                end else begin
                    bit_d = bit_q + 4'd1;
                    sh_d  = {sh_q[6:0], 1'b0};
                    sda_d = sh_q[6];
                end
            end
            E_STOP0: if (tick) begin
                scl_d = 1'b1;
                st_d  = E_STOP1;
            end
            E_STOP1: if (tick) begin
                sda_d = 1'b1;
                done  = 1'b1;
                st_d  = E_IDLE;
            end
            default: st_d = E_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q  <= E_IDLE;
            div_q <= '0;
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            st_q  <= st_d;
            div_q <= div_d;
            scl_q <= scl_d;
            sda_q <= sda_d;
        end
        bit_q  <= bit_d;
        byte_q <= byte_d;
        last_q <= last_d;
        sh_q   <= sh_d;
        dat_q  <= dat_d;
    end

    assign sclk       = scl_q;
    assign sdata      = sda_q;
    assign sdata_oe_n = sda_q;
endmodule

// File: rtl/i2c_ioexp_multi.sv
// Keeps NUM_DEV PCAL6416A expanders' outputs in sync with `in` over one I2C bus.
// Define I2C_IOEXP_PERIODIC_REFRESH_EN to add a periodic full rewrite after init.
module i2c_ioexp_multi
    import i2c_ioexp_pkg::*;
#(
    parameter int                    CLK_DIV_BITS = 10,
    parameter int                    NUM_DEV      = 2,
    parameter logic [NUM_DEV*7-1:0]  DEV_ADDRS    = {7'h21, 7'h20},
    parameter logic [NUM_DEV*16-1:0] OUT_MASK     = '1
`ifdef I2C_IOEXP_PERIODIC_REFRESH_EN
    , parameter int unsigned         REFRESH_CYCLES = 2**20
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_DEV*16-1:0] in,
    input  logic                  refresh,
    output logic                  init_done,
    output logic                  busy,
    output logic                  sclk,
    output logic                  sdata,
    output logic                  sdata_oe_n
);
    ioexp_state_e     state_q, state_d;
    logic [IDX_W-1:0] init_idx_q, init_idx_d, last_idx_q, last_idx_d, sel_q, sel_d, cur;
    logic [NUM_DEV-1:0] dirty_q, dirty_d;
    logic [15:0]      shadow_q [NUM_DEV];
    logic [15:0]      shadow_d [NUM_DEV];
    logic             init_done_q, init_done_d;
    logic             issue, start, done, in_init, found, refresh_int;
    logic [6:0]       addr_mux;
    logic [15:0]      cfg_mux, in_mux;
    logic [7:0]       wr0, wr1, wr2;

`ifdef I2C_IOEXP_PERIODIC_REFRESH_EN
    logic [31:0] rcnt_q, rcnt_d;
    logic        per_tick;

    always_comb begin
        per_tick = init_done_q && (rcnt_q == 32'(REFRESH_CYCLES - 1));
        rcnt_d   = (!init_done_q || per_tick) ? '0 : rcnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) rcnt_q <= '0;
        else       rcnt_q <= rcnt_d;
    end

    assign refresh_int = refresh | per_tick;
`else
    assign refresh_int = refresh;
`endif

    assign in_init = (state_q == INIT_ISSUE) || (state_q == INIT_WAIT);
    assign cur     = in_init ? init_idx_q : sel_q;

    always_comb begin
        addr_mux = '0;
        cfg_mux  = '0;
        in_mux   = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (cur == IDX_W'(i)) begin
                addr_mux = DEV_ADDRS[7*i +: 7];
                cfg_mux  = ~OUT_MASK[16*i +: 16];
                in_mux   = in[16*i +: 16];
            end
        end
        wr0 = in_init ? PCAL_REG_CONFIG0 : PCAL_REG_OUTPUT0;
        wr1 = in_init ? cfg_mux[7:0]  : in_mux[7:0];
        wr2 = in_init ? cfg_mux[15:8] : in_mux[15:8];
    end

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        last_idx_d  = last_idx_q;
        sel_d       = sel_q;
        init_done_d = init_done_q;
        shadow_d    = shadow_q;
        issue       = 1'b0;
        found       = 1'b0;
        // Refresh is only honoured after init: init ends with every bit set anyway.
        for (int i = 0; i < NUM_DEV; i++)
            dirty_d[i] = dirty_q[i] || (in[16*i +: 16] != shadow_q[i]) || (refresh_int && init_done_q);
        case (state_q)
            INIT_ISSUE: begin
                issue   = 1'b1;
                state_d = INIT_WAIT;
            end
            INIT_WAIT: if (done) begin
                if (init_idx_q == IDX_W'(NUM_DEV - 1)) begin
                    init_done_d = 1'b1;
                    dirty_d     = '1;
                    state_d     = IDLE;
                end else begin
                    init_idx_d = init_idx_q + IDX_W'(1);
                    state_d    = INIT_ISSUE;
                end
            end
            IDLE: if (|dirty_q) begin
                // Round robin: first dirty device after the last one serviced.
                for (int k = 1; k <= NUM_DEV; k++)
                    for (int i = 0; i < NUM_DEV; i++)
                        if (!found && dirty_q[i] && ((int'(last_idx_q) + k) % NUM_DEV == i)) begin
                            found = 1'b1;
                            sel_d = IDX_W'(i);
                        end
                state_d = UPD_ISSUE;
            end
            UPD_ISSUE: begin
                issue = 1'b1;
                for (int i = 0; i < NUM_DEV; i++)
                    if (sel_q == IDX_W'(i)) begin
                        shadow_d[i] = in[16*i +: 16];
                        dirty_d[i]  = 1'b0;
                    end
                state_d = UPD_WAIT;
            end
            UPD_WAIT: if (done) begin
                last_idx_d = sel_q;
                state_d    = IDLE;
            end
            default: state_d = INIT_ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT_ISSUE;
            init_idx_q  <= '0;
            last_idx_q  <= IDX_W'(NUM_DEV - 1);
            sel_q       <= '0;
            dirty_q     <= '0;
            init_done_q <= 1'b0;
            for (int i = 0; i < NUM_DEV; i++) shadow_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            last_idx_q  <= last_idx_d;
            sel_q       <= sel_d;
            dirty_q     <= dirty_d;
            init_done_q <= init_done_d;
            shadow_q    <= shadow_d;
        end
    end

    assign start     = issue && !reset;
    assign busy      = !reset && (state_q != IDLE);
    assign init_done = init_done_q;

    i2c_basic #(
        .CLK_DIV_BITS(CLK_DIV_BITS)
    ) u_i2c (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr_mux),
        .num_wr_bytes(2'd3),
        .wr_data0    (wr0),
        .wr_data1    (wr1),
        .wr_data2    (wr2),
        .start       (start),
        .done        (done),
        .sclk        (sclk),
        .sdata       (sdata),
        .sdata_oe_n  (sdata_oe_n)
    );
endmodule
